// File: rtl/r5p_degu_trigger_pkg.sv
// r5p_degu_trigger_pkg: shared types and register map for the degu trigger unit.
package r5p_degu_trigger_pkg;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_EXE = 2'd1,
        MODE_LD  = 2'd2,
        MODE_ST  = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [1:0] REG_CTL = 2'd0;
    localparam logic [1:0] REG_ADR = 2'd1;
    localparam logic [1:0] REG_MSK = 2'd2;
    localparam logic [1:0] REG_CNT = 2'd3;

    localparam int unsigned CTL_MODE_LSB = 0;
    localparam int unsigned CTL_THR_LSB  = 16;

    // STA sits right after the last channel block.
    function automatic int unsigned sta_offset(input int unsigned nch);
        return 4 * nch;
    endfunction

endpackage

// File: rtl/r5p_degu_trigger_channel.sv
// r5p_degu_trigger_channel: one address-compare channel with config registers
// and a saturating hit counter.
module r5p_degu_trigger_channel
    import r5p_degu_trigger_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned CW   = 16
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_trn,
    input  logic [XLEN-1:0] ifu_adr,
    input  logic            lsu_trn,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic            run,
    input  logic            clr,
    input  logic            wen,
    input  logic [1:0]      wsel,
    input  logic [XLEN-1:0] wdt,
    input  logic [1:0]      rsel,
    output logic            fire,
    output logic [XLEN-1:0] rdt
);

    mode_t           mode_q, mode_d;
    logic [CW-1:0]   thr_q, thr_d, cnt_q, cnt_d, cnt_inc, thr_eff;
    logic [XLEN-1:0] adr_q, adr_d, msk_q, msk_d, acc, ctl;
    logic            stb, match, count;

    assign stb = mode_q == MODE_EXE ? ifu_trn :
                 mode_q == MODE_LD  ? lsu_trn && !lsu_wen :
                 mode_q == MODE_ST  ? lsu_trn &&  lsu_wen : 1'b0;
    assign acc     = mode_q == MODE_EXE ? ifu_adr : lsu_adr;
    assign match   = stb && ((acc ^ adr_q) & ~msk_q) == '0;
    // A register write to this channel takes precedence over a coincident match.
    assign count   = run && match && !wen;
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
    assign thr_eff = thr_q == '0 ? CW'(1) : thr_q;
    assign fire    = count && cnt_inc >= thr_eff;

    assign mode_d = wen && wsel == REG_CTL ? mode_t'(wdt[CTL_MODE_LSB +: 2]) : mode_q;
    assign thr_d  = wen && wsel == REG_CTL ? wdt[CTL_THR_LSB +: CW] : thr_q;
    assign adr_d  = wen && wsel == REG_ADR ? wdt : adr_q;
    assign msk_d  = wen && wsel == REG_MSK ? wdt : msk_q;
    assign cnt_d  = clr || (wen && wsel == REG_CNT) ? '0 : count ? cnt_inc : cnt_q;

    always_comb begin
        ctl = '0;
        ctl[CTL_MODE_LSB +: 2] = mode_q;
        ctl[CTL_THR_LSB +: CW] = thr_q;
    end

    assign rdt = rsel == REG_CTL ? ctl :
                 rsel == REG_ADR ? adr_q :
                 rsel == REG_MSK ? msk_q : XLEN'(cnt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_OFF;
            thr_q  <= '0;
            adr_q  <= '0;
            msk_q  <= '0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            thr_q  <= thr_d;
            adr_q  <= adr_d;
            msk_q  <= msk_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/r5p_degu_trigger.sv
// r5p_degu_trigger: breakpoint/watchpoint unit snooping IFU/LSU strobes and
// requesting a CPU halt when a channel reaches its hit threshold.
module r5p_degu_trigger
    import r5p_degu_trigger_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NCH  = 4,
    parameter int unsigned CW   = 16,
    parameter int unsigned AW   = $clog2(4*NCH+1)
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            ifu_trn,
    input  logic [XLEN-1:0] ifu_adr,
    input  logic            lsu_trn,
    input  logic            lsu_wen,
    input  logic [XLEN-1:0] lsu_adr,
    input  logic [1:0]      lsu_siz,
    input  logic            cfg_ena,
    input  logic            cfg_wen,
    input  logic [AW-1:0]   cfg_adr,
    input  logic [XLEN-1:0] cfg_wdt,
    output logic [XLEN-1:0] cfg_rdt,
    output logic [NCH-1:0]  hit,
    output logic            halt_req,
    input  logic            halt_ack,
    input  logic            resume
);

    localparam logic [AW-1:0] STA_ADR = AW'(sta_offset(NCH));

    state_t          state_q, state_d;
    logic [NCH-1:0]  hit_q, hit_d, fire;
    logic [XLEN-1:0] rdt_q, rdt_d, sta;
    logic [XLEN-1:0] ch_rdt [NCH];
    logic            run, clr, sta_wr, cfg_rd, unused_siz;

    assign unused_siz = ^lsu_siz;
    assign run        = state_q == ST_RUN;
    assign clr        = resume && state_q == ST_HALT;
    assign sta_wr     = cfg_ena && cfg_wen && cfg_adr == STA_ADR;
    assign cfg_rd     = cfg_ena && !cfg_wen;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic sel;
        assign sel = cfg_adr[AW-1:2] == (AW-2)'(i);
        r5p_degu_trigger_channel #(.XLEN(XLEN), .CW(CW)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .ifu_trn (ifu_trn),
            .ifu_adr (ifu_adr),
            .lsu_trn (lsu_trn),
            .lsu_wen (lsu_wen),
            .lsu_adr (lsu_adr),
            .run     (run),
            .clr     (clr),
            .wen     (cfg_ena && cfg_wen && sel),
            .wsel    (cfg_adr[1:0]),
            .wdt     (cfg_wdt),
            .rsel    (cfg_adr[1:0]),
            .fire    (fire[i]),
            .rdt     (ch_rdt[i])
        );
    end

    // A new fire beats a same-cycle write-1-to-clear.
    assign hit_d = (hit_q & ~({NCH{sta_wr}} & cfg_wdt[NCH-1:0])) | fire;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (|fire)    state_d = ST_REQ;
            ST_REQ:  if (halt_ack) state_d = ST_HALT;
            ST_HALT: if (resume)   state_d = ST_RUN;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        sta = '0;
        sta[NCH-1:0] = hit_q;
        sta[17:16] = state_q;
        rdt_d = '0;
        for (int k = 0; k < NCH; k++)
            if (cfg_adr[AW-1:2] == (AW-2)'(k)) rdt_d = ch_rdt[k];
        if (cfg_adr == STA_ADR) rdt_d = sta;
        if (!cfg_rd) rdt_d = rdt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            hit_q   <= '0;
            rdt_q   <= '0;
        end else begin
            state_q <= state_d;
            hit_q   <= hit_d;
            rdt_q   <= rdt_d;
        end
    end

    assign cfg_rdt  = rdt_q;
    assign hit      = hit_q;
    assign halt_req = state_q == ST_REQ;

endmodule
